bcd_line_total_seq: RTL and testbench

- Sequential controller that computes a sale line total, PRICE × QTY, entirely in BCD.
- Drives one combinational price-by-digit BCD multiplier, one quantity digit per pass, LSD first.
- Shifts and BCD-accumulates each partial product into a running total.
- Sits between the keypad/price-lookup logic and the receipt/total display path; one request in flight at a time.

---
 rtl/bcd_line_total_seq_pkg.sv | 30 +++
 rtl/bcd_price_digit_mult.sv | 42 ++++
 rtl/bcd_line_total_seq.sv | 209 ++++++++++++++++++++
 tb/tb_bcd_line_total_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_line_total_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_line_total_seq_pkg
// Description : Shared constants, state encoding and small BCD helpers for
//               the BCD line-total sequencer and its price-by-digit
//               multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_line_total_seq_pkg;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_MAX_DIGIT = 9;
    localparam int BCD_ADJ       = 6;

    // Sequencer states. The encoding is fixed so that state dumps read
    // the same on every build.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // True when a nibble is not a legal BCD digit.
    function automatic logic bcd_digit_bad(input logic [BCD_DIGIT_W-1:0] d);
        return (d > BCD_DIGIT_W'(BCD_MAX_DIGIT));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_price_digit_mult.sv
`default_nettype none
// ============================================================================
// Module      : bcd_price_digit_mult
// Description : Combinational BCD multiplier, PRICE_DIGITS-digit multiplicand
//               times one BCD digit, producing PRICE_DIGITS+1 BCD digits.
//               Each digit position forms a small binary product plus the
//               carry from the position below, then splits it into a digit
//               and a carry with a divide-by-10.
// Ports       : i_price   - packed BCD multiplicand, MSD in top nibble
//               i_digit   - single BCD multiplier digit
//               o_product - packed BCD product, PRICE_DIGITS+1 digits
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_price_digit_mult
    import bcd_line_total_seq_pkg::*;
#(
    parameter int PRICE_DIGITS = 3
)(
    input  logic [BCD_DIGIT_W*PRICE_DIGITS-1:0]     i_price,
    input  logic [BCD_DIGIT_W-1:0]                  i_digit,
    output logic [BCD_DIGIT_W*(PRICE_DIGITS+1)-1:0] o_product
);

    // Worst case per position: 9*9 + 8 = 89, which fits in 7 bits, and the
    // outgoing carry never exceeds 8.
    always_comb begin
        logic [6:0] v_prod;
        logic [3:0] v_carry;
        v_prod    = '0;
        v_carry   = '0;
        o_product = '0;
        for (int i = 0; i < PRICE_DIGITS; i++) begin
            v_prod = 7'(i_price[BCD_DIGIT_W*i +: BCD_DIGIT_W]) * 7'(i_digit)
                   + 7'(v_carry);
            o_product[BCD_DIGIT_W*i +: BCD_DIGIT_W] = 4'(v_prod % 7'd10);
            v_carry = 4'(v_prod / 7'd10);
        end
        o_product[BCD_DIGIT_W*PRICE_DIGITS +: BCD_DIGIT_W] = v_carry;
    end

endmodule
`default_nettype wire

// File: rtl/bcd_line_total_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd_line_total_seq
// Description : Sequential BCD line-total engine, TOTAL = PRICE x QTY.
//               One quantity digit per MUL/ACC pass, least significant
//               first; each partial product is shifted into place and
//               BCD-added to a running accumulator. Latency is fixed at
//               2*QTY_DIGITS+1 cycles regardless of the data.
// Ports       : CLK   - clock, rising edge
//               RST   - asynchronous active-high reset
//               START - request, sampled only while idle
//               PRICE - packed BCD multiplicand
//               QTY   - packed BCD multiplier
//               BUSY  - high in every state except idle
//               DONE  - one-cycle pulse, TOTAL valid
//               TOTAL - packed BCD product, held until the next result
//               ERR   - illegal BCD digit seen on accept
// Options     : BCD_INPUT_CHECK_EN - when defined, non-BCD input nibbles
//               abort the request with ERR=1 and TOTAL=0; otherwise ERR
//               is tied low and no checking is done.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_line_total_seq
    import bcd_line_total_seq_pkg::*;
#(
    parameter  int PRICE_DIGITS = 3,
    parameter  int QTY_DIGITS   = 2,
    localparam int TOT_DIGITS   = PRICE_DIGITS + QTY_DIGITS
)(
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                START,
    input  logic [BCD_DIGIT_W*PRICE_DIGITS-1:0] PRICE,
    input  logic [BCD_DIGIT_W*QTY_DIGITS-1:0]   QTY,
    output logic                                BUSY,
    output logic                                DONE,
    output logic [BCD_DIGIT_W*TOT_DIGITS-1:0]   TOTAL,
    output logic                                ERR
);

    localparam int c_price_w = BCD_DIGIT_W * PRICE_DIGITS;
    localparam int c_qty_w   = BCD_DIGIT_W * QTY_DIGITS;
    localparam int c_part_w  = BCD_DIGIT_W * (PRICE_DIGITS + 1);
    localparam int c_tot_w   = BCD_DIGIT_W * TOT_DIGITS;
    localparam int c_idx_w   = (QTY_DIGITS > 1) ? $clog2(QTY_DIGITS) : 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_price_w-1:0] r_price;
    logic [c_qty_w-1:0]   r_qty;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_part_w-1:0]  r_partial;
    logic [c_tot_w-1:0]   r_acc;
    logic [c_tot_w-1:0]   r_total;

    logic [BCD_DIGIT_W-1:0] w_qty_digit;
    logic [c_part_w-1:0]    w_partial;
    logic [c_tot_w-1:0]     w_addend;
    logic [c_tot_w-1:0]     w_acc_sum;
    logic                   w_last;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign w_qty_digit = r_qty[r_idx*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign w_last      = (r_idx == c_idx_w'(QTY_DIGITS - 1));

    bcd_price_digit_mult #(
        .PRICE_DIGITS (PRICE_DIGITS)
    ) u_mult (
        .i_price   (r_price),
        .i_digit   (w_qty_digit),
        .o_product (w_partial)
    );

    // Shifting by whole nibbles places the partial at its decimal weight.
    // For the last digit the partial exactly fills the accumulator width.
    assign w_addend = c_tot_w'(r_partial) << (r_idx * BCD_DIGIT_W);

    // Full-width BCD add with per-digit +6 correction and ripple carry.
    // The final carry is dropped: the product of two maximal operands
    // always fits in TOT_DIGITS.
    always_comb begin
        logic [4:0] v_sum;
        logic       v_c;
        v_sum     = '0;
        v_c       = 1'b0;
        w_acc_sum = '0;
        for (int i = 0; i < TOT_DIGITS; i++) begin
            v_sum = {1'b0, r_acc[BCD_DIGIT_W*i +: BCD_DIGIT_W]}
                  + {1'b0, w_addend[BCD_DIGIT_W*i +: BCD_DIGIT_W]}
                  + {4'b0000, v_c};
            if (v_sum > 5'(BCD_MAX_DIGIT)) begin
                v_sum = v_sum + 5'(BCD_ADJ);
                v_c   = 1'b1;
            end else begin
                v_c   = 1'b0;
            end
            w_acc_sum[BCD_DIGIT_W*i +: BCD_DIGIT_W] = v_sum[3:0];
        end
    end

`ifdef BCD_INPUT_CHECK_EN
    logic w_in_bad;
    logic r_err;

    always_comb begin
        w_in_bad = 1'b0;
        for (int i = 0; i < PRICE_DIGITS; i++) begin
            if (bcd_digit_bad(PRICE[BCD_DIGIT_W*i +: BCD_DIGIT_W])) begin
                w_in_bad = 1'b1;
            end
        end
        for (int i = 0; i < QTY_DIGITS; i++) begin
            if (bcd_digit_bad(QTY[BCD_DIGIT_W*i +: BCD_DIGIT_W])) begin
                w_in_bad = 1'b1;
            end
        end
    end

    // ERR reflects the most recently accepted request only.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (r_state == ST_IDLE && START) begin
            r_err <= w_in_bad;
        end
    end

    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
`ifdef BCD_INPUT_CHECK_EN
                    w_state_nxt = w_in_bad ? ST_FIN : ST_MUL;
`else
                    w_state_nxt = ST_MUL;
`endif
                end
            end
            ST_MUL:  w_state_nxt = ST_ACC;
            ST_ACC:  w_state_nxt = w_last ? ST_FIN : ST_MUL;
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // TOTAL is loaded on the edge that enters FIN so that it is already
    // valid during the DONE cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_price   <= '0;
            r_qty     <= '0;
            r_idx     <= '0;
            r_partial <= '0;
            r_acc     <= '0;
            r_total   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_price <= PRICE;
                        r_qty   <= QTY;
                        r_acc   <= '0;
                        r_idx   <= '0;
`ifdef BCD_INPUT_CHECK_EN
                        if (w_in_bad) begin
                            r_total <= '0;
                        end
`endif
                    end
                end
                ST_MUL: begin
                    r_partial <= w_partial;
                end
                ST_ACC: begin
                    r_acc <= w_acc_sum;
                    if (w_last) begin
                        r_total <= w_acc_sum;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign BUSY  = (r_state != ST_IDLE);
    assign DONE  = (r_state == ST_FIN);
    assign TOTAL = r_total;

endmodule
`default_nettype wire

// File: tb/tb_bcd_line_total_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_line_total_seq
// Description : Self-checking bench for bcd_line_total_seq (default
//               parameters). Directed table of operand/result pairs,
//               hand-written multi-cycle sequences and random BCD operands
//               compared against an integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_line_total_seq;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [11:0] PRICE;
    logic [7:0]  QTY;
    logic        BUSY;
    logic        DONE;
    logic [19:0] TOTAL;
    logic        ERR;

    int n_pass;
    int n_total;

    bcd_line_total_seq #(
        .PRICE_DIGITS (3),
        .QTY_DIGITS   (2)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .PRICE (PRICE),
        .QTY   (QTY),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .TOTAL (TOTAL),
        .ERR   (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [11:0] price;
        logic [7:0]  qty;
        logic [19:0] total;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: decode BCD to integers, multiply, re-encode.
    function automatic longint bcd2int(input logic [31:0] v, input int nd);
        longint r;
        r = 0;
        for (int i = nd - 1; i >= 0; i--) begin
            r = r * 10 + longint'(v[4*i +: 4]);
        end
        return r;
    endfunction

    function automatic logic [19:0] int2bcd(input longint x);
        logic [19:0] r;
        longint      t;
        r = '0;
        t = x;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [19:0] model(input logic [11:0] p,
                                         input logic [7:0] q);
        return int2bcd(bcd2int(32'(p), 3) * bcd2int(32'(q), 2));
    endfunction

    // One START pulse, then wait (bounded) for DONE. lat counts cycles
    // after the accept edge up to and including the DONE cycle.
    task automatic do_req(input logic [11:0] p, input logic [7:0] q,
                          output logic [19:0] tot, output logic err,
                          output int lat, output int busy_cyc);
        @(negedge CLK);
        PRICE = p;
        QTY   = q;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        lat      = 1;
        busy_cyc = 0;
        while (!DONE && lat < 50) begin
            if (BUSY) busy_cyc++;
            @(negedge CLK);
            lat++;
        end
        if (BUSY) busy_cyc++;
        tot = TOTAL;
        err = ERR;
        check("done_seen", 32'(DONE), 32'd1);
        @(negedge CLK);
        check("done_one_cycle", 32'(DONE), 32'd0);
    endtask

    vec_t        vecs[6];
    logic [19:0] tot;
    logic        err;
    int          lat;
    int          busy_cyc;
    int          cyc;
    int          last;
    int          pulses;
    logic [11:0] rp;
    logic [7:0]  rq;

    initial begin
        n_pass  = 0;
        n_total = 0;

        vecs[0] = '{12'h125, 8'h12, 20'h01500};
        vecs[1] = '{12'h999, 8'h99, 20'h98901};
        vecs[2] = '{12'h000, 8'h57, 20'h00000};
        vecs[3] = '{12'h040, 8'h25, 20'h01000};
        vecs[4] = '{12'h321, 8'h45, 20'h14445};
        vecs[5] = '{12'h105, 8'h03, 20'h00315};

        RST   = 1'b1;
        START = 1'b0;
        PRICE = '0;
        QTY   = '0;

        // Reset state
        @(negedge CLK);
        check("rst_busy",  32'(BUSY),  32'd0);
        check("rst_done",  32'(DONE),  32'd0);
        check("rst_total", 32'(TOTAL), 32'd0);
        check("rst_err",   32'(ERR),   32'd0);
        RST = 1'b0;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            do_req(vecs[i].price, vecs[i].qty, tot, err, lat, busy_cyc);
            check($sformatf("tbl%0d_total", i), 32'(tot), 32'(vecs[i].total));
            check($sformatf("tbl%0d_lat", i), 32'(lat), 32'd5);
            check($sformatf("tbl%0d_busy", i), 32'(busy_cyc), 32'd5);
            check($sformatf("tbl%0d_err", i), 32'(err), 32'd0);
        end

        // START held high: a new result every 6 cycles
        @(negedge CLK);
        PRICE = 12'h040;
        QTY   = 8'h25;
        START = 1'b1;
        cyc    = 0;
        last   = 0;
        pulses = 0;
        while (pulses < 3 && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            if (DONE) begin
                check("hold_total", 32'(TOTAL), 32'h01000);
                if (pulses > 0) check("hold_period", 32'(cyc - last), 32'd6);
                last = cyc;
                pulses++;
            end
        end
        check("hold_pulses", 32'(pulses), 32'd3);
        START = 1'b0;
        cyc = 0;
        while (BUSY && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        check("hold_drain", 32'(BUSY), 32'd0);

        // START and operand changes while busy are ignored
        @(negedge CLK);
        PRICE = 12'h040;
        QTY   = 8'h25;
        START = 1'b1;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge CLK);
            cyc++;
            PRICE = 12'h999;
            QTY   = 8'h99;
            START = (cyc <= 3);
            if (DONE) break;
        end
        START = 1'b0;
        check("ign_total", 32'(TOTAL), 32'h01000);
        check("ign_lat", 32'(cyc), 32'd5);
        @(negedge CLK);
        @(negedge CLK);
        check("ign_no_accept", 32'(BUSY), 32'd0);

        // Reset in the middle of a request
        @(negedge CLK);
        PRICE = 12'h321;
        QTY   = 8'h45;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        check("mid_busy_before", 32'(BUSY), 32'd1);
        RST = 1'b1;
        #1;
        check("mid_rst_busy",  32'(BUSY),  32'd0);
        check("mid_rst_done",  32'(DONE),  32'd0);
        check("mid_rst_total", 32'(TOTAL), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("mid_after_done", 32'(DONE), 32'd0);
        check("mid_after_busy", 32'(BUSY), 32'd0);
        do_req(12'h321, 8'h45, tot, err, lat, busy_cyc);
        check("mid_next_total", 32'(tot), 32'h14445);
        check("mid_next_lat", 32'(lat), 32'd5);

`ifdef BCD_INPUT_CHECK_EN
        // Illegal digit: immediate finish with ERR and zero total
        do_req(12'h1A5, 8'h03, tot, err, lat, busy_cyc);
        check("bad_lat",   32'(lat), 32'd1);
        check("bad_err",   32'(err), 32'd1);
        check("bad_total", 32'(tot), 32'd0);
        check("bad_err_hold", 32'(ERR), 32'd1);
        do_req(12'h105, 8'h03, tot, err, lat, busy_cyc);
        check("good_err",   32'(err), 32'd0);
        check("good_total", 32'(tot), 32'h00315);
        check("good_lat",   32'(lat), 32'd5);
`endif

        // Random BCD operands against the reference model
        for (int n = 0; n < 40; n++) begin
            rp = '0;
            rq = '0;
            for (int d = 0; d < 3; d++) rp[4*d +: 4] = 4'($urandom_range(0, 9));
            for (int d = 0; d < 2; d++) rq[4*d +: 4] = 4'($urandom_range(0, 9));
            do_req(rp, rq, tot, err, lat, busy_cyc);
            check($sformatf("rnd%0d_total(%h*%h)", n, rp, rq),
                  32'(tot), 32'(model(rp, rq)));
            check($sformatf("rnd%0d_lat", n), 32'(lat), 32'd5);
            check($sformatf("rnd%0d_err", n), 32'(err), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
